// File: rtl/ucode_sequencer.sv
// Programmable microcode sequencer: a writable table of control words with
// per-entry next-address rules (halt/seq/jump/branch), driving registered
// control signals and a start/busy/done handshake.
module ucode_sequencer #(
    parameter int unsigned       CTRL_W    = 13,
    parameter int unsigned       ADDR_W    = 6,
    parameter int unsigned       CSEL_W    = 2,
    parameter logic [CTRL_W-1:0] IDLE_CTRL = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [CTRL_W+2+CSEL_W+ADDR_W-1:0]  wr_data,
    input  logic                               start,
    input  logic [ADDR_W-1:0]                  start_addr,
    input  logic                               stall,
    input  logic [(2**CSEL_W)-1:0]             cond,
    output logic [CTRL_W-1:0]                  ctrl_out,
    output logic [ADDR_W-1:0]                  upc,
    output logic                               busy,
    output logic                               done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [1:0]        op;
        logic [CSEL_W-1:0] csel;
        logic [ADDR_W-1:0] target;
    } entry_t;

    typedef enum logic [1:0] {
        OP_HALT   = 2'b00,
        OP_SEQ    = 2'b01,
        OP_JUMP   = 2'b10,
        OP_BRANCH = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    entry_t            mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    entry_t            cur_e;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] next_addr;

    // Microcode table; reset clears every entry to HALT with ctrl 0.
    // Reads elsewhere see pre-write contents on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= entry_t'(wr_data);
        end
    end

    // Next-state, next-address and output decode.
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        ctrl_d    = ctrl_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cur_e     = mem_q[upc_q];
        seq_addr  = upc_q + ADDR_W'(1);
        next_addr = seq_addr;

        unique case (op_e'(cur_e.op))
            OP_JUMP:   next_addr = cur_e.target;
            OP_BRANCH: next_addr = cond[cur_e.csel] ? cur_e.target : seq_addr;
            default:   next_addr = seq_addr;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    upc_d   = start_addr;
                    ctrl_d  = mem_q[start_addr].ctrl;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (op_e'(cur_e.op) == OP_HALT) begin
                        state_d = S_IDLE;
                        ctrl_d  = IDLE_CTRL;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        upc_d  = next_addr;
                        ctrl_d = mem_q[next_addr].ctrl;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            upc_q   <= '0;
            ctrl_q  <= IDLE_CTRL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ctrl_out = ctrl_q;
    assign upc      = upc_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
